// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory side bus of the fetch stage.
//   read_address : PC presented to instruction memory (fetch -> memory)
//   instrucao    : instruction word for read_address (memory -> fetch)
//   cond_taken   : branch-condition result, same cycle (comparator -> fetch)
//   exec_en      : current instruction executes this cycle (fetch -> consumers)
// Modports: master = fetch unit, slave = memory / execute side.
interface fetch_unit_if #(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 34
);
  logic [ADDR_W-1:0]  read_address;
  logic [INSTR_W-1:0] instrucao;
  logic               cond_taken;
  logic               exec_en;

  modport master (
    output read_address,
    output exec_en,
    input  instrucao,
    input  cond_taken
  );

  modport slave (
    input  read_address,
    input  exec_en,
    output instrucao,
    output cond_taken
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch / sequencing stage.
// Owns the program counter, chooses the next PC from the returned instruction
// (jumps, BEQ/BNE/BLE, IN stall on operator confirm, HALT), and emits exec_en.
// Ports:
//   clock          rising-edge system clock
//   reset          synchronous, active-low
//   bus            fetch_unit_if.master (read_address, instrucao, cond_taken, exec_en)
//   confirma       asynchronous push-button confirming an IN instruction
//   aguardando_in  stalled on IN waiting for a confirm pulse
//   halted         HALT reached; left only by reset
//   retired        count of executed instructions (wraps)
// Optional feature: define IN_DEBOUNCE_EN to debounce the synchronized
// confirma level over DEBOUNCE_CYCLES consecutive cycles.
module fetch_unit #(
  parameter int ADDR_W          = 10,
  parameter int INSTR_W         = 34,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                clock,
  input  logic                reset,
  fetch_unit_if.master        bus,
  input  logic                confirma,
  output logic                aguardando_in,
  output logic                halted,
  output logic [15:0]         retired
);

  localparam logic [5:0] OP_BEQ  = 6'b001010;
  localparam logic [5:0] OP_BNE  = 6'b001011;
  localparam logic [5:0] OP_BLE  = 6'b001100;
  localparam logic [5:0] OP_IN   = 6'b100000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [1:0] {
    S_START,
    S_RUN,
    S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              exec_en;

  logic [5:0]        opcode;
  logic [ADDR_W-1:0] next_addr;
  logic              unused_bits;

  assign opcode      = bus.instrucao[INSTR_W-1 -: 6];
  assign next_addr   = bus.instrucao[ADDR_W-1:0];
  assign unused_bits = ^bus.instrucao[INSTR_W-7:ADDR_W];

  // Confirm path: 2-flop synchronizer, optional debounce, registered edge detect.
  logic sync1, sync2;
  logic lvl, lvl_prev;
  logic pulse;

`ifdef IN_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic [CNT_W-1:0] deb_cnt;
  logic             deb_level;

  // The level only follows sync2 after DEBOUNCE_CYCLES consecutive mismatches;
  // any agreement restarts the count.
  always_ff @(posedge clock) begin
    if (!reset) begin
      deb_cnt   <= '0;
      deb_level <= 1'b0;
    end else if (sync2 == deb_level) begin
      deb_cnt <= '0;
    end else if (deb_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      deb_level <= sync2;
      deb_cnt   <= '0;
    end else begin
      deb_cnt <= deb_cnt + CNT_W'(1);
    end
  end

  always_comb lvl = deb_level;
`else
  localparam int unused_debounce = DEBOUNCE_CYCLES;
  always_comb lvl = sync2;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      lvl_prev <= 1'b0;
      pulse    <= 1'b0;
    end else begin
      sync1    <= confirma;
      sync2    <= sync1;
      lvl_prev <= lvl;
      pulse    <= lvl & ~lvl_prev;
    end
  end

  // State, PC and retire counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_START;
      pc_q    <= '0;
      retired <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (exec_en) retired <= retired + 16'd1;
    end
  end

  // Next-state / next-PC selection. A pulse outside an IN stall is simply
  // not looked at, so it is dropped rather than remembered.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    exec_en       = 1'b0;
    aguardando_in = 1'b0;
    halted        = 1'b0;
    unique case (state_q)
      S_START: state_d = S_RUN;
      S_RUN: begin
        unique case (opcode)
          OP_BEQ, OP_BNE, OP_BLE: begin
            exec_en = 1'b1;
            pc_d    = bus.cond_taken ? next_addr : pc_q + ADDR_W'(1);
          end
          OP_IN: begin
            if (pulse) begin
              exec_en = 1'b1;
              pc_d    = next_addr;
            end else begin
              aguardando_in = 1'b1;
            end
          end
          OP_HALT: begin
            exec_en = 1'b1;
            state_d = S_HALT;
          end
          default: begin
            exec_en = 1'b1;
            pc_d    = next_addr;
          end
        endcase
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_START;
    endcase
  end

  assign bus.read_address = pc_q;
  assign bus.exec_en      = exec_en;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam int DB = 8;
  localparam logic [5:0] OP_BEQ  = 6'b001010;
  localparam logic [5:0] OP_BNE  = 6'b001011;
  localparam logic [5:0] OP_BLE  = 6'b001100;
  localparam logic [5:0] OP_JUMP = 6'b110000;
  localparam logic [5:0] OP_ADD  = 6'b000001;
  localparam logic [5:0] OP_IN   = 6'b100000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        confirma = 1'b0;
  logic        cond = 1'b0;
  logic        aguardando_in, halted;
  logic [15:0] retired;
  logic [33:0] mem [1024];

  int vectors = 0;
  int miscompares = 0;

  fetch_unit_if #(.ADDR_W(10), .INSTR_W(34)) bus ();

  always_comb bus.instrucao = mem[bus.read_address];
  assign bus.cond_taken = cond;

  fetch_unit #(.ADDR_W(10), .INSTR_W(34), .DEBOUNCE_CYCLES(DB)) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus),
    .confirma      (confirma),
    .aguardando_in (aguardando_in),
    .halted        (halted),
    .retired       (retired)
  );

  always #5 clock = ~clock;

  logic [28:0] obs;
  always_comb obs = {bus.read_address, bus.exec_en, aguardando_in, halted, retired};

  // Reference model: phase 0 = start, 1 = run, 2 = halted.
  int          m_pc, m_phase, e_npc, e_nphase;
  logic [15:0] m_ret;
  logic [15:0] hist;      // confirma samples, bit k = sample k edges ago
  logic        m_pulse;
  logic        e_exec, e_wait, e_halt;
`ifdef IN_DEBOUNCE_EN
  logic        m_deb, m_rose;
`endif

  function automatic logic [33:0] ins(logic [5:0] op, int nxt);
    logic [9:0] n;
    n = nxt[9:0];
    return {op, 18'b0, n};
  endfunction

  function automatic void model_eval();
    logic [5:0] op;
    int nxt;
    op  = mem[m_pc][33:28];
    nxt = int'(mem[m_pc][9:0]);
    e_exec = 0; e_wait = 0; e_halt = 0;
    e_npc = m_pc; e_nphase = m_phase;
    if (m_phase == 0) e_nphase = 1;
    else if (m_phase == 2) e_halt = 1;
    else if (op == OP_HALT) begin e_exec = 1; e_nphase = 2; end
    else if (op == OP_IN) begin
      if (m_pulse) begin e_exec = 1; e_npc = nxt; end
      else e_wait = 1;
    end else if (op == OP_BEQ || op == OP_BNE || op == OP_BLE) begin
      e_exec = 1;
      e_npc  = cond ? nxt : (m_pc + 1) % 1024;
    end else begin
      e_exec = 1; e_npc = nxt;
    end
  endfunction

  function automatic logic [28:0] exp_vec();
    logic [9:0] a;
    model_eval();
    a = m_pc[9:0];
    return {a, e_exec, e_wait, e_halt, m_ret};
  endfunction

  task automatic tick();
    model_eval();
    @(posedge clock);
    if (!reset) begin
      m_pc = 0; m_phase = 0; m_ret = '0; hist = '0; m_pulse = 0;
`ifdef IN_DEBOUNCE_EN
      m_deb = 0; m_rose = 0;
`endif
    end else begin
      if (e_exec) m_ret = m_ret + 16'd1;
      m_pc = e_npc; m_phase = e_nphase;
      hist = {hist[14:0], confirma};
`ifdef IN_DEBOUNCE_EN
      begin
        bit all_new;
        m_pulse = m_rose; m_rose = 0;
        all_new = 1;
        for (int k = 2; k < DB + 2; k++) if (hist[k] == m_deb) all_new = 0;
        if (all_new) begin m_deb = !m_deb; m_rose = m_deb; end
      end
`else
      m_pulse = hist[2] & !hist[3];
`endif
    end
    #1;
  endtask

  task automatic do_reset(int n);
    reset = 0; confirma = 0; cond = 0;
    repeat (n) tick();
    reset = 1;
  endtask

  task automatic fill_seq();
    for (int i = 0; i < 1024; i++) mem[i] = ins(OP_ADD, (i + 1) % 1024);
  endtask

  task automatic test_reset();
    fill_seq();
    reset = 0; confirma = 0; cond = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (obs !== 29'd0 || obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_hold cyc=%0d got=%h expected=%h", i, obs, 29'd0);
      end
    end
    reset = 1; #1;
    vectors++;
    if (bus.exec_en !== 1'b0 || bus.read_address !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_first got addr=%0d exec=%b expected addr=0 exec=0", bus.read_address, bus.exec_en);
    end
    tick();
    vectors++;
    if (bus.exec_en !== 1'b1 || bus.read_address !== 10'd0 || retired !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_exec got addr=%0d exec=%b ret=%0d expected addr=0 exec=1 ret=0", bus.read_address, bus.exec_en, retired);
    end
    tick();
    vectors++;
    if (obs !== exp_vec() || bus.read_address !== 10'd1 || retired !== 16'd1) begin
      miscompares++;
      $display("FAIL reset_second got=%h expected addr=1 ret=1", obs);
    end
  endtask

  task automatic test_fibonacci();
    int visits = 0;
    fill_seq();
    mem[5]  = ins(OP_IN, 6);
    mem[10] = ins(OP_BNE, 6);
    mem[11] = ins(OP_JUMP, 0);
    do_reset(3);
    for (int i = 0; i < 90; i++) begin
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL fib cyc=%0d got=%h expected=%h", i, obs, exp_vec());
      end
      if (i == 15) confirma = 1;
      if (i == 35) confirma = 0;
      if (m_pc == 10) begin cond = (visits < 2); visits++; end
      else cond = 0;
      tick();
    end
    vectors++;
    if (retired !== 16'd27 || bus.read_address !== 10'd5 || aguardando_in !== 1'b1) begin
      miscompares++;
      $display("FAIL fib_end got ret=%0d addr=%0d wait=%b expected ret=27 addr=5 wait=1", retired, bus.read_address, aguardando_in);
    end
  endtask

  task automatic test_branch();
    fill_seq();
    mem[0]  = ins(OP_JUMP, 10);
    mem[10] = ins(OP_BNE, 6);
    mem[6]  = ins(OP_JUMP, 10);
    do_reset(2);
    tick(); tick();
    vectors++;
    if (obs !== exp_vec() || bus.read_address !== 10'd10) begin
      miscompares++;
      $display("FAIL branch_reach got addr=%0d expected 10", bus.read_address);
    end
    cond = 1; tick();
    vectors++;
    if (obs !== exp_vec() || bus.read_address !== 10'd6) begin
      miscompares++;
      $display("FAIL bne_taken got addr=%0d expected 6", bus.read_address);
    end
    tick(); cond = 0; tick();
    vectors++;
    if (obs !== exp_vec() || bus.read_address !== 10'd11) begin
      miscompares++;
      $display("FAIL bne_not_taken got addr=%0d expected 11", bus.read_address);
    end
  endtask

  task automatic test_in_stall();
    int  exec0 = 0;
    bit  prev0 = 0;
    fill_seq();
    mem[0] = ins(OP_IN, 7);
    for (int i = 7; i < 60; i++) mem[i] = ins(OP_JUMP, i + 1);
    mem[60] = ins(OP_IN, 3);
    do_reset(2);
    tick();
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if (obs !== exp_vec() || aguardando_in !== 1'b1 || bus.read_address !== 10'd0 || bus.exec_en !== 1'b0) begin
        miscompares++;
        $display("FAIL in_stall cyc=%0d got=%h expected addr=0 exec=0 wait=1", i, obs);
      end
      tick();
    end
    confirma = 1;
    for (int i = 0; i < 30; i++) begin
      if (prev0) begin
        vectors++;
        if (bus.read_address !== 10'd7) begin
          miscompares++;
          $display("FAIL in_target got addr=%0d expected 7", bus.read_address);
        end
      end
      prev0 = (bus.exec_en === 1'b1 && bus.read_address === 10'd0);
      if (prev0) exec0++;
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL in_confirm cyc=%0d got=%h expected=%h", i, obs, exp_vec());
      end
      if (i == 20) confirma = 0;
      tick();
    end
    vectors++;
    if (exec0 != 1) begin
      miscompares++;
      $display("FAIL in_once got %0d exec cycles expected 1", exec0);
    end
    // Press while running the jump chain; must not release the later IN.
    repeat (5) tick();
    for (int i = 0; i < 52; i++) begin
      confirma = (i < 12);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL in_ignore cyc=%0d got=%h expected=%h", i, obs, exp_vec());
      end
      tick();
    end
    vectors++;
    if (bus.read_address !== 10'd60 || aguardando_in !== 1'b1) begin
      miscompares++;
      $display("FAIL in_discard got addr=%0d wait=%b expected addr=60 wait=1", bus.read_address, aguardando_in);
    end
  endtask

  task automatic test_halt();
    fill_seq();
    mem[4] = ins(OP_HALT, 9);
    do_reset(2);
    repeat (5) tick();
    vectors++;
    if (bus.read_address !== 10'd4 || bus.exec_en !== 1'b1 || halted !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_exec got addr=%0d exec=%b halted=%b expected 4 1 0", bus.read_address, bus.exec_en, halted);
    end
    for (int i = 0; i < 50; i++) begin
      confirma = i[2];
      tick();
      vectors++;
      if (obs !== exp_vec() || obs !== {10'd4, 1'b0, 1'b0, 1'b1, 16'd5}) begin
        miscompares++;
        $display("FAIL halt_frozen cyc=%0d got=%h expected=%h", i, obs, {10'd4, 1'b0, 1'b0, 1'b1, 16'd5});
      end
    end
    reset = 0; tick();
    vectors++;
    if (bus.read_address !== 10'd0 || halted !== 1'b0 || retired !== 16'd0) begin
      miscompares++;
      $display("FAIL halt_reset got addr=%0d halted=%b ret=%0d expected 0 0 0", bus.read_address, halted, retired);
    end
    reset = 1;
  endtask

  task automatic test_wrap();
    fill_seq();
    mem[0]    = ins(OP_JUMP, 1023);
    mem[1023] = ins(OP_BLE, 5);
    do_reset(2);
    tick(); tick();
    vectors++;
    if (bus.read_address !== 10'd1023) begin
      miscompares++;
      $display("FAIL wrap_reach got addr=%0d expected 1023", bus.read_address);
    end
    cond = 0; tick();
    vectors++;
    if (obs !== exp_vec() || bus.read_address !== 10'd0) begin
      miscompares++;
      $display("FAIL wrap_pc got addr=%0d expected 0", bus.read_address);
    end
  endtask

  task automatic test_random();
    logic [5:0] others [5] = '{6'b000000, 6'b000001, 6'b000010, 6'b010101, 6'b111110};
    logic [5:0] op;
    int r;
    for (int i = 0; i < 1024; i++) begin
      r = $urandom_range(0, 99);
      if (r < 10) op = OP_BEQ;
      else if (r < 20) op = OP_BNE;
      else if (r < 30) op = OP_BLE;
      else if (r < 55) op = OP_JUMP;
      else if (r < 75) op = others[$urandom_range(0, 4)];
      else if (r < 93) op = OP_IN;
      else op = OP_HALT;
      mem[i] = ins(op, int'($urandom_range(0, 1023)));
    end
    do_reset(2);
    for (int i = 0; i < 2000; i++) begin
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL random cyc=%0d got=%h expected=%h", i, obs, exp_vec());
      end
      cond  = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 59) != 0);
`ifdef IN_DEBOUNCE_EN
      if ($urandom_range(0, 13) == 0) confirma = !confirma;
`else
      if ($urandom_range(0, 4) == 0) confirma = !confirma;
`endif
      tick();
    end
    reset = 1;
  endtask

`ifdef IN_DEBOUNCE_EN
  task automatic test_debounce();
    int execs = 0;
    fill_seq();
    mem[0] = ins(OP_IN, 9);
    mem[9] = ins(OP_IN, 9);
    do_reset(2);
    tick();
    for (int i = 0; i < 40; i++) begin
      confirma = ((i % 6) < 3);
      vectors++;
      if (obs !== exp_vec() || bus.exec_en !== 1'b0 || bus.read_address !== 10'd0) begin
        miscompares++;
        $display("FAIL debounce_bounce cyc=%0d got=%h expected addr=0 exec=0", i, obs);
      end
      tick();
    end
    confirma = 1;
    for (int i = 0; i < 30; i++) begin
      if (bus.exec_en === 1'b1) execs++;
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL debounce_hold cyc=%0d got=%h expected=%h", i, obs, exp_vec());
      end
      tick();
    end
    vectors++;
    if (execs != 1 || bus.read_address !== 10'd9) begin
      miscompares++;
      $display("FAIL debounce_advance got execs=%0d addr=%0d expected 1 and 9", execs, bus.read_address);
    end
    confirma = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_fibonacci();
    test_branch();
    test_in_stall();
    test_halt();
    test_wrap();
`ifdef IN_DEBOUNCE_EN
    test_debounce();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch / sequencing stage sitting directly upstream of the 34-bit instruction memory: it owns the program counter, drives the memory's 10-bit read address, and chooses the next address from the instruction word it gets back. It resolves jumps and conditional branches, stalls on IN until the operator confirms a switch value, and halts on HALT. It also emits the execute-enable strobe used by the register file and the output display.

## Interface
Parameters:
- ADDR_W, 10, program-counter / read-address width
- INSTR_W, 34, instruction width
- DEBOUNCE_CYCLES, 250000, stable-level cycles required on `confirma` (used only with debounce compiled in)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low
- instrucao  in  INSTR_W  word returned by instruction memory for `read_address`
- cond_taken  in  1  branch-condition result from comparator, same cycle
- confirma  in  1  asynchronous operator push-button for IN
- read_address  out  ADDR_W  current PC to instruction memory
- exec_en  out  1  current instruction executes this cycle
- aguardando_in  out  1  stalled on IN
- halted  out  1  HALT reached
- retired  out  16  count of executed instructions

## Operation
- Field split: opcode = instrucao[33:28], next = instrucao[9:0] (encoded next/target address).
- States: START, RUN, HALT.
  - START: entered on reset; exec_en=0; PC held at 0; advances to RUN after 1 cycle.
  - RUN: next-PC selection by opcode:
    - 001010 BEQ / 001011 BNE / 001100 BLE: PC ← cond_taken ? next : PC+1.
    - 110000 JUMP and all other opcodes: PC ← next.
    - 100000 IN: PC held and exec_en=0 until a confirm pulse; in the pulse cycle exec_en=1 and PC ← next.
    - 111111 HALT: exec_en=1 for one cycle, then → HALT.
  - HALT: PC frozen, exec_en=0, halted=1; left only by reset.
- PC+1 is modulo 2^ADDR_W (1023 → 0).
- Confirm pulse: `confirma` passed through a 2-flop synchronizer; a rising edge of the synchronized level yields a 1-cycle pulse. A pulse arriving while not stalled on IN is discarded, not queued.
- aguardando_in = RUN & opcode==IN & no pulse this cycle.
- retired increments on every exec_en cycle; wraps at 65535 → 0.

## Timing
- All state changes on the rising edge of `clock`; instrucao treated as combinational from read_address within the cycle.
- Reset (reset==0 at an edge): PC=0, state=START, exec_en=0, aguardando_in=0, halted=0, retired=0, synchronizer, edge and debounce registers cleared. This applies from any state, including mid-stall and HALT.
- First executed instruction: the second rising edge after reset is released.
- Branch/jump latency: 0 bubbles; the target is on read_address the cycle after the branch executes.
- IN latency from a `confirma` rising edge to exec_en: 3 cycles without debounce (2 sync + edge register), and 3 + DEBOUNCE_CYCLES cycles with debounce.
- exec_en, aguardando_in and halted are combinational from registered state plus the current instrucao/pulse; no glitch requirement beyond the single clock.

## Configuration
- IN_DEBOUNCE_EN defined: the synchronized `confirma` must hold a new level for DEBOUNCE_CYCLES consecutive cycles before the debounced level updates; the edge detect runs on the debounced level. The counter restarts on any mismatch.
- Undefined: no debounce counter; edge detect runs directly on the synchronizer output.

## Test plan
- Reset held 3 cycles, then released → read_address=0, exec_en=0 in first cycle after release, exec_en=1 next; retired=0 before execution.
- Fibonacci program, IN at address 5, switches = 3 → addresses 0,1,2,3,4,5(stall),6..10, loop back to 6 while BNE taken, then 11 → 0; retired counts correctly.
- BNE at address 10 with next=6: cond_taken=1 → read_address 6; cond_taken=0 → 11.
- IN stall: no confirma for 20 cycles → aguardando_in=1, PC constant, exec_en=0. Confirma pulse → exactly one exec_en cycle, then PC=next. Confirma pressed while not on IN → ignored.
- HALT (opcode 111111) at address 4 → one exec_en cycle, then halted=1 and PC frozen for 50 cycles. Reset low → PC=0, halted=0.
- With IN_DEBOUNCE_EN and DEBOUNCE_CYCLES=8: confirma bouncing 3-cycle pulses → no advance; level held 8+ cycles → one advance.
